// File: rtl/gcd_pkg.sv
// Shared types and default sizes for the subtractive GCD engine.
package gcd_pkg;

    localparam int GCD_WIDTH_DEF  = 8;
    localparam int GCD_ITER_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gcd_state_e;

endpackage

// File: rtl/gcd_datapath.sv
// Operand registers, comparator flags and single subtractor for the GCD engine.
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_in_i,
    input  logic [WIDTH-1:0] b_in_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             a_zero_o,
    output logic             b_zero_o,
    output logic             eq_o,
    output logic             gt_o
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    assign a_zero_o = (a_q == '0);
    assign b_zero_o = (b_q == '0);
    assign eq_o     = (a_q == b_q);
    assign gt_o     = (a_q > b_q);
    assign a_o      = a_q;
    assign b_o      = b_q;

    // The larger register is always the minuend, so the subtract never wraps.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (load_i) begin
            a_d = a_in_i;
            b_d = b_in_i;
        end else if (step_i) begin
            if (gt_o) a_d = a_q - b_q;
            else      b_d = b_q - a_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

endmodule

// File: rtl/gcd_engine.sv
// Subtractive GCD unit with valid/ready on both sides and synchronous abort.
// Optional subtract counter and out_iters port when GCD_ITER_COUNT_EN is defined.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH  = GCD_WIDTH_DEF
`ifdef GCD_ITER_COUNT_EN
   ,parameter int ITER_W = GCD_ITER_W_DEF
`endif
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_gcd
`ifdef GCD_ITER_COUNT_EN
   ,output logic [ITER_W-1:0] out_iters
`endif
);

    gcd_state_e       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_gcd_q, out_gcd_d;
    logic             load, step, finish;
    logic [WIDTH-1:0] a, b;
    logic             a_zero, b_zero, eq, gt;

    gcd_datapath #(.WIDTH(WIDTH)) u_dp (
        .clock    (clock),
        .reset_n  (reset_n),
        .load_i   (load),
        .step_i   (step),
        .a_in_i   (in_a),
        .b_in_i   (in_b),
        .a_o      (a),
        .b_o      (b),
        .a_zero_o (a_zero),
        .b_zero_o (b_zero),
        .eq_o     (eq),
        .gt_o     (gt)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_gcd   = out_gcd_q;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_gcd_d   = out_gcd_q;
        load        = 1'b0;
        step        = 1'b0;
        finish      = 1'b0;
        // clear overrides everything; out_gcd deliberately keeps its last value
        if (clear) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (in_valid) begin
                    load    = 1'b1;
                    state_d = CALC;
                end
                CALC: if (a_zero || b_zero || eq) begin
                    finish      = 1'b1;
                    out_gcd_d   = a_zero ? b : a;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    step = 1'b1;
                end
                DONE: if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_gcd_q   <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_gcd_q   <= out_gcd_d;
        end
    end

`ifdef GCD_ITER_COUNT_EN
    logic [ITER_W-1:0] iters_q, out_iters_q;

    assign out_iters = out_iters_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            iters_q     <= '0;
            out_iters_q <= '0;
        end else begin
            if (load)                       iters_q <= '0;
            else if (step && iters_q != '1) iters_q <= iters_q + 1'b1;
            if (finish)                     out_iters_q <= iters_q;
        end
    end
`endif

endmodule
